// File: rtl/control_booth.sv
// rtl/control_booth.sv - operand capture, multiplier launch, timeout and signed BCD conversion
module control_booth #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CONV_CYCLES    = 16
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        pb_pulse,
    input  logic [7:0]  multiplicador,
    input  logic [7:0]  multiplicando,
    input  logic        mult_done,
    input  logic [15:0] mult_result,
    output logic [7:0]  op_a,
    output logic [7:0]  op_b,
    output logic        mult_valid,
    output logic [20:0] codigo_BCD,
    output logic        busy,
    output logic        result_ready,
    output logic        error_timeout
);

    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CCNT_W = $clog2(CONV_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CONVERT,
        S_SHOW
    } state_t;

    state_t state;
    state_t state_next;

    logic [WCNT_W-1:0] wait_cnt;
    logic [CCNT_W-1:0] conv_cnt;
    logic              sign_r;
    logic [15:0]       bin_sr;
    logic [19:0]       bcd_sr;
    logic [19:0]       bcd_adj;
    logic [15:0]       magnitude;
    logic              timeout_hit;
    logic              conv_last;

    // Last permitted WAIT cycle; a done on this same cycle still takes priority.
    assign timeout_hit = (wait_cnt == WCNT_W'(TIMEOUT_CYCLES - 1));
    assign conv_last   = (conv_cnt == CCNT_W'(CONV_CYCLES - 1));
    assign magnitude   = mult_result[15] ? (~mult_result + 16'd1) : mult_result;

    // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < 5; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; pb_pulse is only honoured in IDLE and mult_done only in WAIT.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (pb_pulse) state_next = S_LAUNCH;
            S_LAUNCH:  state_next = S_WAIT;
            S_WAIT: begin
                if (mult_done) begin
                    state_next = S_CONVERT;
                end else if (timeout_hit) begin
                    state_next = S_IDLE;
                end
            end
            S_CONVERT: if (conv_last) state_next = S_SHOW;
            S_SHOW:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Registered datapath and outputs; codigo_BCD is written only in SHOW.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            op_a          <= '0;
            op_b          <= '0;
            mult_valid    <= 1'b0;
            codigo_BCD    <= '0;
            busy          <= 1'b0;
            result_ready  <= 1'b0;
            error_timeout <= 1'b0;
            wait_cnt      <= '0;
            conv_cnt      <= '0;
            sign_r        <= 1'b0;
            bin_sr        <= '0;
            bcd_sr        <= '0;
        end else begin
            mult_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pb_pulse) begin
                        op_a          <= multiplicador;
                        op_b          <= multiplicando;
                        busy          <= 1'b1;
                        result_ready  <= 1'b0;
                        error_timeout <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    mult_valid <= 1'b1;
                    wait_cnt   <= '0;
                end
                S_WAIT: begin
                    if (mult_done) begin
                        sign_r   <= mult_result[15];
                        bin_sr   <= magnitude;
                        bcd_sr   <= '0;
                        conv_cnt <= '0;
                    end else if (timeout_hit) begin
                        error_timeout <= 1'b1;
                        busy          <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_CONVERT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj[18:0], bin_sr, 1'b0};
                    conv_cnt         <= conv_cnt + 1'b1;
                end
                S_SHOW: begin
                    codigo_BCD   <= {sign_r, bcd_sr};
                    result_ready <= 1'b1;
                    busy         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_booth.sv
// tb/tb_control_booth.sv - randomized self-checking bench for control_booth
module tb_control_booth;

    logic        CLK100MHZ;
    logic        reset;
    logic        pb_pulse;
    logic [7:0]  multiplicador;
    logic [7:0]  multiplicando;
    logic        mult_done;
    logic [15:0] mult_result;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        mult_valid;
    logic [20:0] codigo_BCD;
    logic        busy;
    logic        result_ready;
    logic        error_timeout;

    int          checks;
    int          errors;
    logic [20:0] exp_display;

    control_booth dut (
        .CLK100MHZ     (CLK100MHZ),
        .reset         (reset),
        .pb_pulse      (pb_pulse),
        .multiplicador (multiplicador),
        .multiplicando (multiplicando),
        .mult_done     (mult_done),
        .mult_result   (mult_result),
        .op_a          (op_a),
        .op_b          (op_b),
        .mult_valid    (mult_valid),
        .codigo_BCD    (codigo_BCD),
        .busy          (busy),
        .result_ready  (result_ready),
        .error_timeout (error_timeout)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    // Sign-magnitude decimal rendering of a signed 16-bit product.
    function automatic logic [20:0] bcd_model(input logic [15:0] p);
        int v;
        int m;
        v = int'($signed(p));
        m = (v < 0) ? -v : v;
        return {(v < 0), 4'(m / 10000 % 10), 4'(m / 1000 % 10), 4'(m / 100 % 10),
                4'(m / 10 % 10), 4'(m % 10)};
    endfunction

    function automatic logic [15:0] product(input logic [7:0] a, input logic [7:0] b);
        int pa;
        int pb;
        pa = int'($signed(a));
        pb = int'($signed(b));
        return 16'(pa * pb);
    endfunction

    // One full operation: capture at edge k, done sampled at edge k+lat, display at k+lat+17.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] res, input int lat, input bit interfere,
                          input logic [20:0] exp_code);
        int vcount;
        @(negedge CLK100MHZ);
        multiplicador = a;
        multiplicando = b;
        pb_pulse      = 1'b1;
        @(negedge CLK100MHZ);
        pb_pulse = 1'b0;
        checks += 6;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_on_accept: got %b expected 1", name, busy); end
        if (op_a !== a) begin errors++; $display("FAIL %s op_a_capture: got %h expected %h", name, op_a, a); end
        if (op_b !== b) begin errors++; $display("FAIL %s op_b_capture: got %h expected %h", name, op_b, b); end
        if (result_ready !== 1'b0) begin errors++; $display("FAIL %s ready_cleared: got %b expected 0", name, result_ready); end
        if (error_timeout !== 1'b0) begin errors++; $display("FAIL %s timeout_cleared: got %b expected 0", name, error_timeout); end
        if (mult_valid !== 1'b0) begin errors++; $display("FAIL %s valid_at_k: got %b expected 0", name, mult_valid); end
        @(negedge CLK100MHZ);
        vcount = 0;
        checks++;
        if (mult_valid !== 1'b1) begin errors++; $display("FAIL %s valid_at_k1: got %b expected 1", name, mult_valid); end
        else vcount++;
        for (int c = 2; c < lat; c++) begin
            pb_pulse = interfere && (c % 4 == 0);
            if (pb_pulse) begin
                multiplicador = 8'($urandom);
                multiplicando = 8'($urandom);
            end
            @(negedge CLK100MHZ);
            if (mult_valid === 1'b1) vcount++;
        end
        pb_pulse    = 1'b0;
        mult_done   = 1'b1;
        mult_result = res;
        @(negedge CLK100MHZ);
        mult_done   = 1'b0;
        mult_result = 16'($urandom);
        if (mult_valid === 1'b1) vcount++;
        for (int i = 1; i <= 16; i++) begin
            pb_pulse  = interfere && (i % 5 == 2);
            mult_done = interfere && (i % 5 == 3);
            if (pb_pulse) begin
                multiplicador = 8'($urandom);
                multiplicando = 8'($urandom);
            end
            if (mult_done) mult_result = 16'($urandom);
            @(negedge CLK100MHZ);
            if (mult_valid === 1'b1) vcount++;
        end
        pb_pulse  = 1'b0;
        mult_done = 1'b0;
        checks += 3;
        if (result_ready !== 1'b0) begin errors++; $display("FAIL %s ready_early: got %b expected 0", name, result_ready); end
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_during_convert: got %b expected 1", name, busy); end
        if (codigo_BCD !== exp_display) begin errors++; $display("FAIL %s display_held: got %h expected %h", name, codigo_BCD, exp_display); end
        @(negedge CLK100MHZ);
        if (mult_valid === 1'b1) vcount++;
        checks += 7;
        if (codigo_BCD !== exp_code) begin errors++; $display("FAIL %s codigo_BCD: got %h expected %h", name, codigo_BCD, exp_code); end
        if (result_ready !== 1'b1) begin errors++; $display("FAIL %s result_ready: got %b expected 1", name, result_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_off: got %b expected 0", name, busy); end
        if (error_timeout !== 1'b0) begin errors++; $display("FAIL %s no_timeout: got %b expected 0", name, error_timeout); end
        if (op_a !== a) begin errors++; $display("FAIL %s op_a_stable: got %h expected %h", name, op_a, a); end
        if (op_b !== b) begin errors++; $display("FAIL %s op_b_stable: got %h expected %h", name, op_b, b); end
        if (vcount != 1) begin errors++; $display("FAIL %s valid_pulses: got %0d expected 1", name, vcount); end
        exp_display = exp_code;
    endtask

    task automatic test_reset();
        checks += 6;
        if (codigo_BCD !== 21'h0) begin errors++; $display("FAIL reset_codigo: got %h expected 0", codigo_BCD); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (result_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", result_ready); end
        if (error_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", error_timeout); end
        if (mult_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", mult_valid); end
        if ({op_a, op_b} !== 16'h0) begin errors++; $display("FAIL reset_ops: got %h expected 0", {op_a, op_b}); end
        @(negedge CLK100MHZ);
        multiplicador = 8'd7;
        multiplicando = 8'd9;
        pb_pulse      = 1'b1;
        @(negedge CLK100MHZ);
        pb_pulse = 1'b0;
        repeat (5) @(negedge CLK100MHZ);
        reset = 1'b0;
        #1;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_async_busy: got %b expected 0", busy); end
        if ({op_a, op_b} !== 16'h0) begin errors++; $display("FAIL reset_async_ops: got %h expected 0", {op_a, op_b}); end
        repeat (3) @(negedge CLK100MHZ);
        reset = 1'b1;
        @(negedge CLK100MHZ);
        mult_done   = 1'b1;
        mult_result = 16'h1234;
        @(negedge CLK100MHZ);
        mult_done = 1'b0;
        repeat (20) @(negedge CLK100MHZ);
        checks += 4;
        if (codigo_BCD !== 21'h0) begin errors++; $display("FAIL stray_done_codigo: got %h expected 0", codigo_BCD); end
        if (result_ready !== 1'b0) begin errors++; $display("FAIL stray_done_ready: got %b expected 0", result_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL stray_done_busy: got %b expected 0", busy); end
        if (mult_valid !== 1'b0) begin errors++; $display("FAIL stray_done_valid: got %b expected 0", mult_valid); end
        exp_display = 21'h0;
    endtask

    task automatic test_directed();
        run_op("basic_5x3", 8'd5, 8'd3, 16'd15, 10, 1'b0, 21'h000015);
        run_op("max_pos", 8'h80, 8'h80, 16'h4000, 10, 1'b0, 21'h016384);
        run_op("max_neg", 8'h80, 8'h7F, 16'hC080, 10, 1'b0, 21'h116256);
        run_op("zero", 8'h00, 8'h9C, 16'h0000, 2, 1'b0, 21'h000000);
        run_op("minus_one", 8'hFF, 8'h01, 16'hFFFF, 3, 1'b0, 21'h100001);
    endtask

    task automatic test_timeout();
        int cycles;
        @(negedge CLK100MHZ);
        multiplicador = 8'd12;
        multiplicando = 8'd34;
        pb_pulse      = 1'b1;
        @(negedge CLK100MHZ);
        pb_pulse = 1'b0;
        cycles = 0;
        while (error_timeout !== 1'b1 && cycles < 100) begin
            @(negedge CLK100MHZ);
            cycles++;
        end
        checks += 5;
        if (cycles < 64 || cycles > 66) begin errors++; $display("FAIL timeout_latency: got %0d expected 64..66", cycles); end
        if (error_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", error_timeout); end
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy); end
        if (codigo_BCD !== exp_display) begin errors++; $display("FAIL timeout_codigo: got %h expected %h", codigo_BCD, exp_display); end
        if (result_ready !== 1'b0) begin errors++; $display("FAIL timeout_ready: got %b expected 0", result_ready); end
        repeat (4) @(negedge CLK100MHZ);
        checks++;
        if (error_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", error_timeout); end
        run_op("after_timeout", 8'd12, 8'd34, 16'd408, 7, 1'b0, 21'h000408);
    endtask

    task automatic test_interference();
        run_op("interfere", 8'hF6, 8'd25, 16'hFF06, 12, 1'b1, 21'h100250);
    endtask

    task automatic test_random();
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        for (int n = 0; n < 20; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            p = product(a, b);
            run_op("random", a, b, p, int'($urandom_range(2, 40)), n[0], bcd_model(p));
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_1", 8'd99, 8'd99, 16'd9801, 2, 1'b0, bcd_model(16'd9801));
        run_op("b2b_2", 8'h9D, 8'd100, product(8'h9D, 8'd100), 2, 1'b0, bcd_model(product(8'h9D, 8'd100)));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_display   = 21'h0;
        reset         = 1'b0;
        pb_pulse      = 1'b0;
        multiplicador = 8'h0;
        multiplicando = 8'h0;
        mult_done     = 1'b0;
        mult_result   = 16'h0;
        repeat (3) @(negedge CLK100MHZ);
        reset = 1'b1;
        @(negedge CLK100MHZ);
        test_reset();
        test_directed();
        test_timeout();
        test_interference();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
